// File: rtl/morse_decoder.sv
// morse_decoder: times key presses/gaps on a tick base and decodes Morse into 6-bit character codes
module morse_decoder #(
    parameter int CNT_W     = 8,
    parameter int MIN_PRESS = 2,
    parameter int DOT_MAX   = 6,
    parameter int GAP_CHAR  = 10,
    parameter int GAP_WORD  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       key,
    output logic [5:0] data,
    output logic       valid,
    output logic       err,
    output logic       wspace,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PRESS);
    localparam logic [CNT_W-1:0] DOT_C  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] CHAR_C = CNT_W'(GAP_CHAR);
    localparam logic [CNT_W-1:0] WORD_C = CNT_W'(GAP_WORD);

    state_t           state_q, state_d;
    logic [5:0]       data_q, data_d;
    logic             valid_q, valid_d, err_q, err_d, wspace_q, wspace_d;
    logic [4:0]       sym_code_q, sym_code_d;
    logic [2:0]       sym_width_q, sym_width_d;
    logic             ovf_q, ovf_d, word_arm_q, word_arm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             hit;
    logic [5:0]       idx;

    // Returns {hit, index}; code holds the first symbol at bit width-1.
    function automatic logic [6:0] lookup(input logic [2:0] w, input logic [4:0] c);
        case ({w, c})
            8'b101_11111: lookup = {1'b1, 6'd0};
            8'b101_01111: lookup = {1'b1, 6'd1};
            8'b101_00111: lookup = {1'b1, 6'd2};
            8'b101_00011: lookup = {1'b1, 6'd3};
            8'b101_00001: lookup = {1'b1, 6'd4};
            8'b101_00000: lookup = {1'b1, 6'd5};
            8'b101_10000: lookup = {1'b1, 6'd6};
            8'b101_11000: lookup = {1'b1, 6'd7};
            8'b101_11100: lookup = {1'b1, 6'd8};
            8'b101_11110: lookup = {1'b1, 6'd9};
            8'b010_00001: lookup = {1'b1, 6'd10};
            8'b100_01000: lookup = {1'b1, 6'd11};
            8'b100_01010: lookup = {1'b1, 6'd12};
            8'b011_00100: lookup = {1'b1, 6'd13};
            8'b001_00000: lookup = {1'b1, 6'd14};
            8'b100_00010: lookup = {1'b1, 6'd15};
            8'b011_00110: lookup = {1'b1, 6'd16};
            8'b100_00000: lookup = {1'b1, 6'd17};
            8'b010_00000: lookup = {1'b1, 6'd18};
            8'b100_00111: lookup = {1'b1, 6'd19};
            8'b011_00101: lookup = {1'b1, 6'd20};
            8'b100_00100: lookup = {1'b1, 6'd21};
            8'b010_00011: lookup = {1'b1, 6'd22};
            8'b010_00010: lookup = {1'b1, 6'd23};
            8'b011_00111: lookup = {1'b1, 6'd24};
            8'b100_00110: lookup = {1'b1, 6'd25};
            8'b100_01101: lookup = {1'b1, 6'd26};
            8'b011_00010: lookup = {1'b1, 6'd27};
            8'b011_00000: lookup = {1'b1, 6'd28};
            8'b001_00001: lookup = {1'b1, 6'd29};
            8'b011_00001: lookup = {1'b1, 6'd30};
            8'b100_00001: lookup = {1'b1, 6'd31};
            8'b011_00011: lookup = {1'b1, 6'd32};
            8'b100_01001: lookup = {1'b1, 6'd33};
            8'b100_01011: lookup = {1'b1, 6'd34};
            8'b100_01100: lookup = {1'b1, 6'd35};
            default:      lookup = 7'd0;
        endcase
    endfunction

    assign {hit, idx} = lookup(sym_width_q, sym_code_q);
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        wspace_d    = 1'b0;
        sym_code_d  = sym_code_q;
        sym_width_d = sym_width_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        word_arm_d  = word_arm_q;
        case (state_q)
            IDLE: begin
                if (key) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end else if (word_arm_q && tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == WORD_C) begin
                        wspace_d   = 1'b1;
                        word_arm_d = 1'b0;
                    end
                end
            end
            PRESS: begin
                if (key) begin
                    if (tick) cnt_d = cnt_inc;
                end else if (cnt_q < MIN_C) begin
                    state_d = (sym_width_q == 3'd0) ? IDLE : GAP;
                    cnt_d   = (sym_width_q == 3'd0) ? cnt_q : '0;
                end else begin
                    state_d = GAP;
                    cnt_d   = '0;
                    if (sym_width_q == 3'd5) begin
                        ovf_d = 1'b1;
                    end else begin
                        sym_code_d  = {sym_code_q[3:0], cnt_q >= DOT_C};
                        sym_width_d = sym_width_q + 3'd1;
                    end
                end
            end
            GAP: begin
                if (key) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CHAR_C) begin
                        err_d       = ovf_q || !hit;
                        valid_d     = !ovf_q && hit;
                        data_d      = (!ovf_q && hit) ? idx : data_q;
                        sym_code_d  = '0;
                        sym_width_d = '0;
                        ovf_d       = 1'b0;
                        word_arm_d  = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            wspace_q    <= 1'b0;
            sym_code_q  <= '0;
            sym_width_q <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            word_arm_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            wspace_q    <= wspace_d;
            sym_code_q  <= sym_code_d;
            sym_width_q <= sym_width_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            word_arm_q  <= word_arm_d;
        end
    end

    assign data   = data_q;
    assign valid  = valid_q;
    assign err    = err_q;
    assign wspace = wspace_q;
    assign busy   = (state_q == PRESS) || (state_q == GAP);
endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
Receives a single-bit Morse key, times presses and gaps against a tick time base, and assembles dot/dash symbols. At each character gap it emits the 6-bit character code used across the design (0-9 = digits, 10-35 = A-Z), or an error. It is the receive-side counterpart of the character-to-Morse encoder; key input comes from the board's synchronised, debounced key line.

Parameters:
CNT_W, 8, width of the press and gap tick counters; counters saturate at 2^CNT_W-1
MIN_PRESS, 2, presses shorter than this many ticks are glitches and are discarded
DOT_MAX, 6, a press of at least MIN_PRESS and fewer than DOT_MAX ticks is a dot; DOT_MAX or more is a dash
GAP_CHAR, 10, released ticks that end a character
GAP_WORD, 30, released ticks, counted from the last release, that signal a word space

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
tick  input  1  time-base strobe; counters advance only on cycles where tick=1
key  input  1  1 = key pressed; already synchronised to clk
data  output  6  last decoded character, 0-35
valid  output  1  one-cycle pulse; data updated this cycle
err  output  1  one-cycle pulse; character overflowed or is not in the table
wspace  output  1  one-cycle pulse; word gap detected
busy  output  1  1 when state is PRESS or GAP

Behaviour:
- Reset, applied at the clk edge while rst=1, clears everything: state=IDLE, data=0, valid=0, err=0, wspace=0, sym_code=0, sym_width=0, ovf=0, counters=0, word_arm=0. Reset mid-character discards the partial character with no pulse.
- Symbol encoding uses the shared table. dot=0, dash=1. The first symbol ends up at bit sym_width-1 and the last at bit 0. Each new symbol is appended with sym_code <= {sym_code[3:0], s} and sym_width <= sym_width+1.
- Digits (always 5 symbols):
  - 0 = -----.
  - n = 1-5: n dots, then dashes.
  - n = 6-9: n-5 dashes, then dots.
- Letters 10-35 are A-Z in standard international Morse. Examples: A=01/2, B=1000/4, E=0/1, T=1/1, Q=1101/4, Z=1100/4.
- State IDLE:
  - key=1: go to PRESS, cnt=0.
  - Otherwise, if word_arm=1, cnt counts ticks. When cnt reaches GAP_WORD: wspace=1 for one cycle, word_arm=0.
- State PRESS:
  - Each tick while key=1 increments cnt (saturating).
  - On a cycle with key=0:
    - cnt<MIN_PRESS: glitch, nothing appended. If sym_width=0, go to IDLE (word_arm and cnt are left as they were). Otherwise go to GAP with cnt=0.
    - Otherwise: s=(cnt>=DOT_MAX). If sym_width=5, set ovf=1 and leave sym_code/sym_width unchanged; else append s. Go to GAP with cnt=0.
- State GAP:
  - key=1 takes priority: go to PRESS, cnt=0 (the same character continues).
  - Otherwise each tick increments cnt. On the edge where cnt reaches GAP_CHAR, one of the following registers, and they are mutually exclusive:
    - ovf=1, or no table entry for (sym_code, sym_width): err=1, data unchanged.
    - Otherwise: data <= table index, valid=1.
  - In both cases: clear sym_code, sym_width and ovf; set word_arm=1; keep cnt counting (the word gap is measured from the release); state=IDLE.
- Pulse timing: valid/err rise in the cycle after the GAP_CHAR-th gap tick, and wspace in the cycle after the GAP_WORD-th tick counted from the last release. Each pulse lasts exactly one cycle.
- No-match examples: width-5 patterns other than digits, and width-4 patterns 0011, 0101, 1110, 1111.
- data holds its value between valid pulses.
- tick=0 freezes all counters; key edges are still acted on.
- At most one of valid/err is asserted per character. wspace fires at most once per idle period and never for a glitch-only press from reset.

Test Plan:
Bench settings: defaults, tick=1 every cycle, dot = 3-tick press, dash = 9-tick press, intra-character gap = 3 ticks.
- Dot, gap, dash, then release for 10 ticks -> valid=1 for one cycle with data=10 (A), err=0, busy=0 afterwards.
- Five dashes -> data=0. Dot then four dashes -> data=1. Dash, dash, then three dots -> data=7.
- Six dots -> err=1 once, valid=0, data keeps its previous value. A following single dash decodes data=29 (T).
- Dash, dash, dash, dash (1111) -> err=1. One-tick press from IDLE -> no pulse, busy returns to 0, no wspace.
- E, then idle -> valid with data=14 at gap tick 10, wspace=1 exactly once at tick 30 after release. A press at gap tick 9 instead makes the next symbol part of the same character (dot, dot -> data=18, I).
- Reset asserted midway through B (after 2 symbols) -> no valid/err, all outputs 0. A subsequent T decodes data=29.
